// File: rtl/virtio_avail_ring_poller.sv
// Virtio avail-ring poller: turns QueueNotify writes into per-queue avail->idx fetches over AXI4 read.
// Optional forced periodic polling of all ready queues is enabled by defining VIRTIO_AVAIL_POLL_EN.
module virtio_avail_ring_poller #(
  parameter int unsigned NUM_Q         = 3,
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned POLL_INTERVAL = 1024
) (
  input  logic                  clk,
  input  logic                  csr_rst_n,
  input  logic                  queue_notify_wr,
  input  logic [15:0]           queue_notify_data,
  input  logic [NUM_Q-1:0]      queue_ready,
  input  logic [NUM_Q*ADDR_W-1:0] queue_avail_addr,
  output logic [NUM_Q-1:0]      queue_notify_set,
  output logic [NUM_Q-1:0]      queue_notify_clr,
  output logic [NUM_Q-1:0]      ring_available_set,
  output logic [NUM_Q*16-1:0]   next_avail_idx,
  output logic                  rd_error,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arid,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int unsigned IDX_W     = 16;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_UPD} state_t;

  state_t              state_q, state_d;
  logic [NUM_Q-1:0]    pend_q, pend_d;
  logic [NUM_Q-1:0]    sel_q, sel_d;
  logic [NUM_Q-1:0]    notify_hit, notify_acc, cand, pick, poll_set;
  logic [NUM_Q-1:0]    clr_d, avail_d;
  logic [NUM_Q*IDX_W-1:0] idx_d;
  logic [ADDR_W-1:0]   araddr_d;
  logic [IDX_W-1:0]    rdata_idx_q, cur_idx;
  logic [1:0]          rresp_q;
  logic                rd_err_d, found;
  logic                unused_ok;

  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = 4'd0;

  // Decode the notify index against every queue so out-of-range values never alias.
  always_comb begin
    notify_hit = '0;
    for (int i = 0; i < int'(NUM_Q); i++) begin
      if (queue_notify_data == 16'(i)) notify_hit[i] = 1'b1;
    end
  end

  assign notify_acc = notify_hit & queue_ready & {NUM_Q{queue_notify_wr}};

  // Lowest-index serviceable queue and its address, dword aligned.
  always_comb begin
    cand     = pend_q & queue_ready;
    pick     = '0;
    found    = 1'b0;
    araddr_d = '0;
    for (int i = 0; i < int'(NUM_Q); i++) begin
      if (cand[i] && !found) begin
        pick[i]  = 1'b1;
        found    = 1'b1;
        araddr_d = queue_avail_addr[i*ADDR_W +: ADDR_W];
      end
    end
    araddr_d[1:0] = 2'b00;
  end

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < int'(NUM_Q); i++) begin
      if (sel_q[i]) cur_idx = next_avail_idx[i*IDX_W +: IDX_W];
    end
  end

`ifdef VIRTIO_AVAIL_POLL_EN
  localparam int unsigned CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  logic [CNT_W-1:0] poll_cnt_q;
  logic             poll_wrap;

  assign poll_wrap = (poll_cnt_q == CNT_W'(POLL_INTERVAL - 1));
  assign poll_set  = poll_wrap ? queue_ready : '0;
  assign unused_ok = ^{m_axi_rlast, m_axi_rdata[15:0]};

  always_ff @(posedge clk or negedge csr_rst_n) begin
    if (!csr_rst_n) poll_cnt_q <= '0;
    else            poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + CNT_W'(1);
  end
`else
  assign poll_set  = '0;
  assign unused_ok = ^{m_axi_rlast, m_axi_rdata[15:0], 32'(POLL_INTERVAL)};
`endif

  // Next-state and update logic; notify sets are applied after the UPD clear so they win.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pend_d   = pend_q;
    clr_d    = '0;
    avail_d  = '0;
    rd_err_d = 1'b0;
    idx_d    = next_avail_idx;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = pick;
          state_d = S_AR;
        end
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R:  if (m_axi_rvalid)  state_d = S_UPD;
      S_UPD: begin
        state_d = S_IDLE;
        clr_d   = sel_q;
        pend_d  = pend_q & ~sel_q;
        if (rresp_q == RESP_OKAY) begin
          if (rdata_idx_q != cur_idx) avail_d = sel_q;
          for (int i = 0; i < int'(NUM_Q); i++) begin
            if (sel_q[i]) idx_d[i*IDX_W +: IDX_W] = rdata_idx_q;
          end
        end else begin
          rd_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = pend_d | notify_acc | poll_set;
  end

  always_ff @(posedge clk or negedge csr_rst_n) begin
    if (!csr_rst_n) begin
      state_q            <= S_IDLE;
      pend_q             <= '0;
      sel_q              <= '0;
      rdata_idx_q        <= '0;
      rresp_q            <= 2'b00;
      queue_notify_set   <= '0;
      queue_notify_clr   <= '0;
      ring_available_set <= '0;
      next_avail_idx     <= '0;
      rd_error           <= 1'b0;
      m_axi_araddr       <= '0;
      m_axi_arvalid      <= 1'b0;
      m_axi_rready       <= 1'b0;
    end else begin
      state_q            <= state_d;
      pend_q             <= pend_d;
      sel_q              <= sel_d;
      queue_notify_set   <= notify_acc;
      queue_notify_clr   <= clr_d;
      ring_available_set <= avail_d;
      next_avail_idx     <= idx_d;
      rd_error           <= rd_err_d;
      m_axi_arvalid      <= (state_d == S_AR);
      m_axi_rready       <= (state_d == S_R);
      if (state_q == S_IDLE && state_d == S_AR) m_axi_araddr <= araddr_d;
      if (state_q == S_R && m_axi_rvalid) begin
        rdata_idx_q <= m_axi_rdata[31:16];
        rresp_q     <= m_axi_rresp;
      end
    end
  end
endmodule

// File: tb/tb_virtio_avail_ring_poller.sv
// Directed bench for virtio_avail_ring_poller with a zero-wait single-beat AXI read slave.
module tb_virtio_avail_ring_poller;
  localparam int NQ = 3;
  localparam int AW = 64;

  logic              clk = 1'b0;
  logic              csr_rst_n;
  logic              queue_notify_wr;
  logic [15:0]       queue_notify_data;
  logic [NQ-1:0]     queue_ready;
  logic [NQ*AW-1:0]  queue_avail_addr;
  logic [NQ-1:0]     queue_notify_set, queue_notify_clr, ring_available_set;
  logic [NQ*16-1:0]  next_avail_idx;
  logic              rd_error;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic [3:0]        m_axi_arid;
  logic              m_axi_arvalid, m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_data_cfg;
  logic [1:0]  rd_resp_cfg;
  logic        owe;
  int          ar_cnt, err_cnt;
  logic [63:0] ar_addr [16];
  int          set_cnt [NQ];
  int          clr_cnt [NQ];
  int          avail_cnt [NQ];
  int          b_ar, b_err;
  int          b_set [NQ];
  int          b_clr [NQ];
  int          b_avail [NQ];
  int          d_ar, d_err;
  logic [11:0] d_set, d_clr, d_avail;

  always #5 clk = ~clk;

  virtio_avail_ring_poller #(.NUM_Q(NQ), .ADDR_W(AW), .POLL_INTERVAL(1024)) dut (
    .clk(clk), .csr_rst_n(csr_rst_n),
    .queue_notify_wr(queue_notify_wr), .queue_notify_data(queue_notify_data),
    .queue_ready(queue_ready), .queue_avail_addr(queue_avail_addr),
    .queue_notify_set(queue_notify_set), .queue_notify_clr(queue_notify_clr),
    .ring_available_set(ring_available_set), .next_avail_idx(next_avail_idx),
    .rd_error(rd_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // AXI slave plus pulse counters, all updated on the falling edge.
  initial begin
    owe = 1'b0; ar_cnt = 0; err_cnt = 0;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    for (int i = 0; i < NQ; i++) begin set_cnt[i] = 0; clr_cnt[i] = 0; avail_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NQ; i++) begin
        set_cnt[i]   += int'(queue_notify_set[i]);
        clr_cnt[i]   += int'(queue_notify_clr[i]);
        avail_cnt[i] += int'(ring_available_set[i]);
      end
      err_cnt += int'(rd_error);
      if (m_axi_rvalid) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end else if (owe && m_axi_rready) begin
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        m_axi_rdata  = rd_data_cfg;
        m_axi_rresp  = rd_resp_cfg;
        owe          = 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        owe = 1'b1;
        if (ar_cnt < 16) ar_addr[ar_cnt] = m_axi_araddr;
        ar_cnt++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic notify(input logic [15:0] q);
    queue_notify_wr   = 1'b1;
    queue_notify_data = q;
    wait_cyc(1);
    queue_notify_wr   = 1'b0;
  endtask

  task automatic snap();
    b_ar = ar_cnt; b_err = err_cnt;
    for (int i = 0; i < NQ; i++) begin b_set[i] = set_cnt[i]; b_clr[i] = clr_cnt[i]; b_avail[i] = avail_cnt[i]; end
  endtask

  task automatic delta();
    d_ar = ar_cnt - b_ar; d_err = err_cnt - b_err;
    for (int i = 0; i < NQ; i++) begin
      d_set[i*4 +: 4]   = 4'(set_cnt[i] - b_set[i]);
      d_clr[i*4 +: 4]   = 4'(clr_cnt[i] - b_clr[i]);
      d_avail[i*4 +: 4] = 4'(avail_cnt[i] - b_avail[i]);
    end
  endtask

  task automatic test_reset();
    csr_rst_n = 1'b0;
    queue_notify_wr = 1'b0; queue_notify_data = '0; queue_ready = 3'b111;
    queue_avail_addr = {64'hABCD_0000_0000_3008, 64'h0000_0000_0000_1000, 64'h0000_0000_2000_0003};
    rd_data_cfg = '0; rd_resp_cfg = 2'b00;
    wait_cyc(3);
    total++;
    if (next_avail_idx !== 48'h0) begin bad++; $display("FAIL reset_idx got %h want 0", next_avail_idx); end
    total++;
    if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin bad++; $display("FAIL reset_axi got %b want 00", {m_axi_arvalid, m_axi_rready}); end
    total++;
    if ({queue_notify_set, queue_notify_clr, ring_available_set, rd_error} !== 10'd0) begin
      bad++; $display("FAIL reset_pulses got %b want 0", {queue_notify_set, queue_notify_clr, ring_available_set, rd_error});
    end
    total++;
    if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid} !== {8'd0, 3'b010, 2'b01, 4'd0}) begin
      bad++; $display("FAIL axi_consts got %h want %h", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid}, {8'd0, 3'b010, 2'b01, 4'd0});
    end
    @(negedge clk); csr_rst_n = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_first_fetch();
    rd_data_cfg = 32'h0005_0000; rd_resp_cfg = 2'b00;
    snap();
    notify(16'd1);
    total++;
    if (queue_notify_set !== 3'b010) begin bad++; $display("FAIL notify_set_latency got %b want 010", queue_notify_set); end
    wait_cyc(10);
    delta();
    total++;
    if (d_ar !== 1 || ar_addr[b_ar] !== 64'h1000) begin bad++; $display("FAIL first_read got n=%0d addr=%h want n=1 addr=1000", d_ar, ar_addr[b_ar]); end
    total++;
    if (d_avail !== 12'h010 || d_clr !== 12'h010) begin bad++; $display("FAIL first_pulses got avail=%h clr=%h want 010 010", d_avail, d_clr); end
    total++;
    if (next_avail_idx !== 48'h0000_0005_0000) begin bad++; $display("FAIL first_idx got %h want 000000050000", next_avail_idx); end
  endtask

  task automatic test_repeat_same();
    snap();
    notify(16'd1);
    wait_cyc(10);
    delta();
    total++;
    if (d_ar !== 1 || d_avail !== 12'h000 || d_clr !== 12'h010 || d_set !== 12'h010) begin
      bad++; $display("FAIL repeat_same got n=%0d avail=%h clr=%h set=%h want 1 000 010 010", d_ar, d_avail, d_clr, d_set);
    end
  endtask

  task automatic test_back_to_back();
    rd_data_cfg = 32'h0007_0000;
    snap();
    notify(16'd0);
    notify(16'd2);
    wait_cyc(16);
    delta();
    total++;
    if (d_ar !== 2 || ar_addr[b_ar] !== 64'h2000_0000 || ar_addr[b_ar+1] !== 64'hABCD_0000_0000_3008) begin
      bad++; $display("FAIL b2b_order got n=%0d a0=%h a1=%h want 2 20000000 abcd000000003008", d_ar, ar_addr[b_ar], ar_addr[b_ar+1]);
    end
    total++;
    if (d_avail !== 12'h101 || d_clr !== 12'h101) begin bad++; $display("FAIL b2b_pulses got avail=%h clr=%h want 101 101", d_avail, d_clr); end
    total++;
    if (next_avail_idx !== 48'h0007_0005_0007) begin bad++; $display("FAIL b2b_idx got %h want 000700050007", next_avail_idx); end
  endtask

  task automatic test_reject();
    queue_ready = 3'b110;
    snap();
    notify(16'd3);
    notify(16'd0);
    notify(16'h8001);
    wait_cyc(8);
    queue_ready = 3'b111;
    wait_cyc(8);
    delta();
    total++;
    if (d_set !== 12'h000 || d_ar !== 0) begin bad++; $display("FAIL reject got set=%h reads=%0d want 000 0", d_set, d_ar); end
  endtask

  task automatic test_ready_drop();
    snap();
    notify(16'd2);
    queue_ready = 3'b011;
    wait_cyc(8);
    delta();
    total++;
    if (d_ar !== 0 || d_set !== 12'h100) begin bad++; $display("FAIL ready_drop_hold got reads=%0d set=%h want 0 100", d_ar, d_set); end
    queue_ready = 3'b111;
    wait_cyc(8);
    delta();
    total++;
    if (d_ar !== 1 || d_clr !== 12'h100 || d_avail !== 12'h000) begin
      bad++; $display("FAIL ready_drop_resume got reads=%0d clr=%h avail=%h want 1 100 000", d_ar, d_clr, d_avail);
    end
  endtask

  task automatic test_slverr();
    rd_data_cfg = 32'h0009_0000; rd_resp_cfg = 2'b10;
    snap();
    notify(16'd1);
    wait_cyc(12);
    delta();
    rd_resp_cfg = 2'b00;
    total++;
    if (d_err !== 1 || d_clr !== 12'h010 || d_avail !== 12'h000 || d_ar !== 1) begin
      bad++; $display("FAIL slverr got err=%0d clr=%h avail=%h reads=%0d want 1 010 000 1", d_err, d_clr, d_avail, d_ar);
    end
    total++;
    if (next_avail_idx !== 48'h0007_0005_0007) begin bad++; $display("FAIL slverr_idx got %h want 000700050007", next_avail_idx); end
  endtask

  task automatic test_collision();
    rd_data_cfg = 32'h000A_0000;
    snap();
    notify(16'd1);
    wait_cyc(3);
    queue_notify_wr = 1'b1; queue_notify_data = 16'd1;
    wait_cyc(1);
    queue_notify_wr = 1'b0;
    total++;
    if (queue_notify_set !== 3'b010 || queue_notify_clr !== 3'b010) begin
      bad++; $display("FAIL collision_pulses got set=%b clr=%b want 010 010", queue_notify_set, queue_notify_clr);
    end
    wait_cyc(10);
    delta();
    total++;
    if (d_ar !== 2 || d_clr !== 12'h020 || d_avail !== 12'h010) begin
      bad++; $display("FAIL collision_refetch got reads=%0d clr=%h avail=%h want 2 020 010", d_ar, d_clr, d_avail);
    end
  endtask

  task automatic test_wrap();
    rd_data_cfg = 32'hFFFF_0000;
    snap();
    notify(16'd0);
    wait_cyc(10);
    rd_data_cfg = 32'h0000_1234;
    notify(16'd0);
    wait_cyc(10);
    delta();
    total++;
    if (d_avail !== 12'h002 || d_ar !== 2) begin bad++; $display("FAIL wrap_pulses got avail=%h reads=%0d want 002 2", d_avail, d_ar); end
    total++;
    if (next_avail_idx !== 48'h0007_000A_0000) begin bad++; $display("FAIL wrap_idx got %h want 0007000a0000", next_avail_idx); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_repeat_same();
    test_back_to_back();
    test_reject();
    test_ready_drop();
    test_slverr();
    test_collision();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/virtio_avail_ring_poller.md
Name: virtio_avail_ring_poller

Overview:
- Device-side virtio front end for virtqueue notifications.
- Records queue-notify writes from the virtio CSR block as per-queue pending flags.
- Fetches each pending queue's avail->idx over a single-beat AXI4 read.
- Publishes the fetched index as next_avail_idx and pulses ring_available_set when new descriptors exist, feeding the descriptor-fetch stage.

Parameters:
NUM_Q, 3, number of virtqueues (queue indices 0..NUM_Q-1)
ADDR_W, 64, AXI address width
POLL_INTERVAL, 1024, cycles between forced polls (optional feature only)

Ports:
clk  in  1  clock; all logic on rising edge
csr_rst_n  in  1  asynchronous active-low reset
queue_notify_wr  in  1  one-cycle strobe: driver wrote QueueNotify
queue_notify_data  in  16  queue index written
queue_ready  in  NUM_Q  per-queue enable from CSR
queue_avail_addr  in  NUM_Q*ADDR_W  per-queue avail ring base; queue q occupies bits [q*ADDR_W +: ADDR_W]
queue_notify_set  out  NUM_Q  one-cycle pulse: notify accepted for queue q
queue_notify_clr  out  NUM_Q  one-cycle pulse: pending for queue q consumed by a completed fetch
ring_available_set  out  NUM_Q  one-cycle pulse: fetched idx differs from previous next_avail_idx
next_avail_idx  out  NUM_Q*16  last fetched avail->idx per queue
rd_error  out  1  one-cycle pulse on RRESP != OKAY
m_axi_araddr  out  ADDR_W  read address
m_axi_arlen  out  8  constant 0
m_axi_arsize  out  3  constant 3'b010 (4 bytes)
m_axi_arburst  out  2  constant INCR (2'b01)
m_axi_arid  out  4  constant 0
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat; ignored (single beat)
m_axi_rvalid  in  1  data valid
m_axi_rready  out  1  data ready

Behaviour:
- Reset values (async, csr_rst_n=0): all pending flags 0; all pulse outputs 0; next_avail_idx 0 for every queue; m_axi_arvalid 0; m_axi_rready 0; FSM in IDLE.
- Notify acceptance: queue_notify_wr with queue_notify_data < NUM_Q and queue_ready[q]=1:
  - sets pending[q] at the next edge;
  - pulses queue_notify_set[q] that same cycle (registered, 1-cycle latency);
  - pending already set: flag stays 1, pulse still issued.
- Notify rejection: index >= NUM_Q or queue not ready -> ignored, no pulse.
- FSM states:
  - IDLE: pick the lowest-index q with pending[q]=1 and queue_ready[q]=1; latch q. Go to AR.
  - AR: arvalid=1, araddr = queue_avail_addr[q] with bits [1:0] forced 0. Hold address stable until arready. Go to R.
  - R: rready=1. On rvalid go to UPD, capturing rdata and rresp.
  - UPD: 1 cycle, then IDLE.
- UPD with rresp=OKAY:
  - new_idx = rdata[31:16] (flags in [15:0], little-endian);
  - ring_available_set[q] pulses if new_idx != next_avail_idx[q]; then next_avail_idx[q] <= new_idx;
  - queue_notify_clr[q] pulses and pending[q] clears.
- UPD with rresp != OKAY: rd_error pulses; pending[q] clears; queue_notify_clr[q] pulses; next_avail_idx unchanged; no ring_available_set.
- Set/clear collision: a notify accepted in the UPD cycle for the same q wins. pending stays 1 (refetch follows); queue_notify_set and queue_notify_clr both pulse.
- Index comparison uses full 16-bit equality; wrap-around 0xFFFF->0x0000 counts as a change.
- queue_ready[q] dropping while pending: flag is kept but not serviced until ready returns. An in-flight fetch completes normally.
- Throughput: at most one outstanding read; minimum 4 cycles per fetch with zero-wait AXI.

Optional Feature:
- Macro VIRTIO_AVAIL_POLL_EN.
- Defined: a free-running counter reaching POLL_INTERVAL-1 sets pending for every ready queue, then wraps to 0. Forced polls produce no queue_notify_set pulse; they recover lost notifications.
- Undefined: counter absent; pending set only by notify writes.

Test Plan:
- Reset, then notify q=1 with avail_addr[1]=0x1000, slave returns 0x0005_0000 OKAY -> one read at araddr 0x1000, ring_available_set=3'b010, next_avail_idx[1]=5, queue_notify_clr[1] pulse.
- Repeat notify q=1 with the same data 0x0005_0000 -> read issued, no ring_available_set, clr pulses.
- Notify q=0 and q=2 on consecutive cycles -> q0 fetched first, then q2; two reads in order.
- Notify q=3, and notify q=0 with queue_ready[0]=0 -> no pulses, no AXI activity.
- Slave returns RRESP=SLVERR -> rd_error pulse, next_avail_idx unchanged, pending cleared.
- next_avail_idx[0]=0xFFFF, read returns idx 0x0000 -> ring_available_set[0] pulses.
